ex_hazard_ctrl: RTL
===================

Name: ex_hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage RISC-V pipeline.
- Keeps a shadow copy of destination and control info for the EX, MEM and WB stages.
- Detects load-use and branch/jump hazards and drives PC/IF-ID write enables, flushes and bubbles.
- Generates operand-forwarding selects for the EX-stage ALU A and B inputs. Sits beside the ID/EX register, and its outputs feed the PC mux, the pipeline registers and the EX operand muxes.

Parameters:
- REG_ADDR_W, 5, register-address width.
- CNT_W, 32, width of the stall and flush performance counters.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- id_valid  input  1  ID stage holds a real instruction.
- id_rs1_addr  input  REG_ADDR_W  rs1 of the ID instruction.
- id_rs2_addr  input  REG_ADDR_W  rs2 of the ID instruction.
- id_rs1_used  input  1  ID instruction reads rs1.
- id_rs2_used  input  1  ID instruction reads rs2.
- id_rd_addr  input  REG_ADDR_W  rd of the ID instruction.
- id_reg_write  input  1  ID instruction writes rd.
- id_mem_read  input  1  ID instruction is a load.
- id_branch  input  1  ID instruction is a conditional branch (taken on zero).
- id_jump  input  1  ID instruction is an unconditional jump.
- ex_zero  input  1  ALU zero flag of the instruction currently in EX.
- pc_write  output  1  PC load enable (0 = hold).
- if_id_write  output  1  IF/ID register load enable (0 = hold).
- if_id_flush  output  1  zero the IF/ID register on the next edge.
- id_ex_flush  output  1  load a bubble into ID/EX on the next edge.
- pc_src  output  1  1 = PC takes the EX branch target (PC+Imm).
- fwd_a_sel  output  2  ALU A source: 00 regfile, 10 EX/MEM ALU result, 01 WB data.
- fwd_b_sel  output  2  Rs2 source, same encoding as fwd_a_sel.
- stall_cnt  output  CNT_W  cycles spent stalling.
- flush_cnt  output  CNT_W  redirects taken.

Behaviour:
- Reset values, with rst low, asynchronous:
  - All shadow valid bits are 0.
  - pc_write = 1, if_id_write = 1, if_id_flush = 0, id_ex_flush = 0, pc_src = 0.
  - fwd_a_sel = fwd_b_sel = 00.
  - stall_cnt = flush_cnt = 0.
  - Reset mid-stall or mid-flush abandons it immediately; the first cycle after rst rises behaves as an empty pipeline.
- Shadow pipeline, every rising edge:
  - WB <- MEM, MEM <- EX.
  - EX <- ID fields (rs1, rs2, rd, reg_write, mem_read, branch, jump, valid).
  - If id_ex_flush = 1, EX is loaded as a bubble: valid = 0 and all controls 0.
  - An EX entry counts as writing only when valid & reg_write & rd != 0. x0 never matches for hazard or forwarding.
- Redirect (combinational from EX shadow):
  - taken = ex_valid & ((ex_branch & ex_zero) | ex_jump).
  - When taken: pc_src = 1, pc_write = 1, if_id_flush = 1, id_ex_flush = 1.
  - Latency is 2 squashed slots: the instructions in IF and ID.
- Load-use stall:
  - Condition: id_valid & EX entry is a writing load & rd matches a used rs1 or rs2.
  - Response: pc_write = 0, if_id_write = 0, id_ex_flush = 1, for exactly 1 cycle.
  - On the next cycle the load is in MEM and no stall is raised by it.
- Priority: redirect beats stall. If both conditions hold, perform the redirect only, with no stall cycle.
- Forwarding selects (combinational from shadow EX rs fields against MEM and WB):
  - 10 if the MEM entry is writing and mem_rd == ex_rs; else 01 if the WB entry is writing and wb_rd == ex_rs; else 00.
  - MEM has priority over WB when both match.
  - A load in MEM never asserts 10; load-use stalling guarantees this case cannot occur.
- Counters:
  - stall_cnt increments each cycle pc_write = 0.
  - flush_cnt increments each cycle pc_src = 1.
  - Both saturate at all-ones and do not wrap.
- The register file writes in the first half-cycle, so a WB-stage write is visible to ID with no hazard.

Optional Feature:
- Macro: FORWARDING_EN.
- Defined: forwarding and single-cycle load-use stall exactly as described under Behaviour.
- Undefined:
  - fwd_a_sel and fwd_b_sel are constant 00.
  - Any RAW between an ID source and a writing EX or MEM entry stalls, with the same signals as a load-use stall.
  - A dependency on EX therefore stalls 2 cycles; a dependency on MEM stalls 1 cycle.
  - Redirect priority and the counters are unchanged.

Test Plan:
- Reset: assert rst = 0 mid-stream, then release -> all outputs at reset values; stall_cnt = 0; the next independent instruction issues with no stall.
- ALU-ALU RAW (FORWARDING_EN): add x5 in EX, then sub using rs1 = x5 -> no stall; the following cycle fwd_a_sel = 10. One instruction later, a dependent op gets fwd_b_sel = 01.
- Load-use: lw x6 in EX, ID uses rs2 = x6 -> pc_write = 0, if_id_write = 0, id_ex_flush = 1 for 1 cycle; stall_cnt = 1; next cycle fwd_b_sel = 01.
- Taken beq: ex_branch = 1, ex_zero = 1 -> pc_src = 1, if_id_flush = 1, id_ex_flush = 1 for 1 cycle; flush_cnt = 1.
- Not-taken beq: ex_zero = 0 -> no flush; pc_src = 0.
- Redirect beats stall: jump in EX simultaneous with a load-use match in ID -> only the redirect occurs; stall_cnt unchanged. Without FORWARDING_EN, add x7 in EX followed by a user of x7 -> exactly 2 stall cycles.

Source files
------------

// File: rtl/ex_hazard_ctrl_if.sv
// Hazard-controller port bundle: ID-stage decode info and EX zero flag in,
// PC/pipeline-register controls, forwarding selects and perf counters out.
interface ex_hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs1_addr;
    logic [REG_ADDR_W-1:0] id_rs2_addr;
    logic                  id_rs1_used;
    logic                  id_rs2_used;
    logic [REG_ADDR_W-1:0] id_rd_addr;
    logic                  id_reg_write;
    logic                  id_mem_read;
    logic                  id_branch;
    logic                  id_jump;
    logic                  ex_zero;

    logic                  pc_write;
    logic                  if_id_write;
    logic                  if_id_flush;
    logic                  id_ex_flush;
    logic                  pc_src;
    logic [1:0]            fwd_a_sel;
    logic [1:0]            fwd_b_sel;
    logic [CNT_W-1:0]      stall_cnt;
    logic [CNT_W-1:0]      flush_cnt;

    modport master (
        output id_valid, id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
               id_rd_addr, id_reg_write, id_mem_read, id_branch, id_jump, ex_zero,
        input  pc_write, if_id_write, if_id_flush, id_ex_flush, pc_src,
               fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
               id_rd_addr, id_reg_write, id_mem_read, id_branch, id_jump, ex_zero,
        output pc_write, if_id_write, if_id_flush, id_ex_flush, pc_src,
               fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/ex_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline with EX/MEM/WB shadow state.
// FORWARDING_EN: ALU forwarding + 1-cycle load-use stall; undefined: stall on any EX/MEM RAW.
module ex_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input logic             clk,
    input logic             rst,
    ex_hazard_ctrl_if.slave hz
);
    localparam int STAGES = 2;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
        logic                  branch;
        logic                  jump;
    } ex_ent_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
    } wr_ent_t;

    // vld_pipe[0] = EX, [1] = MEM, [2] = WB
    logic [STAGES:0]  vld_pipe;
    ex_ent_t          ex_q;
    wr_ent_t          mem_q;
    wr_ent_t          wb_q;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;
    logic             ex_wr;
    logic             mem_wr;
    logic             wb_wr;
    logic             ex_dep;
    logic             taken;
    logic             hazard;
    logic             stall;
    logic             bubble;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe <= '0;
            ex_q     <= '0;
            mem_q    <= '0;
            wb_q     <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], hz.id_valid & ~bubble};
            if (bubble) begin
                ex_q <= '0;
            end else begin
                ex_q <= '{rs1: hz.id_rs1_addr, rs2: hz.id_rs2_addr, rd: hz.id_rd_addr,
                          reg_write: hz.id_reg_write, mem_read: hz.id_mem_read,
                          branch: hz.id_branch, jump: hz.id_jump};
            end
            mem_q <= '{rd: ex_q.rd, reg_write: ex_q.reg_write, mem_read: ex_q.mem_read};
            wb_q  <= mem_q;
        end
    end

    // x0 writes are architecturally dropped, so they never create a dependency
    assign ex_wr  = vld_pipe[0] & ex_q.reg_write  & (ex_q.rd  != '0);
    assign mem_wr = vld_pipe[1] & mem_q.reg_write & (mem_q.rd != '0);
    assign wb_wr  = vld_pipe[2] & wb_q.reg_write  & (wb_q.rd  != '0);

    assign ex_dep = (hz.id_rs1_used & (hz.id_rs1_addr == ex_q.rd)) |
                    (hz.id_rs2_used & (hz.id_rs2_addr == ex_q.rd));

    assign taken  = vld_pipe[0] & ((ex_q.branch & hz.ex_zero) | ex_q.jump);

`ifdef FORWARDING_EN
    function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs,
                                           input logic                  mem_ok,
                                           input logic                  wb_ok,
                                           input logic [REG_ADDR_W-1:0] mem_rd,
                                           input logic [REG_ADDR_W-1:0] wb_rd);
        if (mem_ok && (mem_rd == rs))     fwd_sel = 2'b10;
        else if (wb_ok && (wb_rd == rs))  fwd_sel = 2'b01;
        else                              fwd_sel = 2'b00;
    endfunction

    logic mem_fwd_ok;
    logic unused;

    // A load's data is not ready in MEM; the load-use stall keeps this path dead
    assign mem_fwd_ok   = mem_wr & ~mem_q.mem_read;
    assign hazard       = hz.id_valid & ex_wr & ex_q.mem_read & ex_dep;
    assign hz.fwd_a_sel = fwd_sel(ex_q.rs1, mem_fwd_ok, wb_wr, mem_q.rd, wb_q.rd);
    assign hz.fwd_b_sel = fwd_sel(ex_q.rs2, mem_fwd_ok, wb_wr, mem_q.rd, wb_q.rd);
    assign unused       = wb_q.mem_read;
`else
    logic mem_dep;
    logic unused;

    assign mem_dep = (hz.id_rs1_used & (hz.id_rs1_addr == mem_q.rd)) |
                     (hz.id_rs2_used & (hz.id_rs2_addr == mem_q.rd));
    assign hazard       = hz.id_valid & ((ex_wr & ex_dep) | (mem_wr & mem_dep));
    assign hz.fwd_a_sel = 2'b00;
    assign hz.fwd_b_sel = 2'b00;
    assign unused       = ^{ex_q.rs1, ex_q.rs2, mem_q.mem_read, wb_q.mem_read, wb_wr};
`endif

    // Redirect squashes the ID instruction anyway, so it overrides any stall
    assign stall  = hazard & ~taken;
    assign bubble = taken | stall;

    assign hz.pc_write    = ~stall;
    assign hz.if_id_write = ~stall;
    assign hz.if_id_flush = taken;
    assign hz.id_ex_flush = bubble;
    assign hz.pc_src      = taken;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (stall && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
            if (taken && (flush_q != '1)) flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign hz.stall_cnt = stall_q;
    assign hz.flush_cnt = flush_q;
endmodule
